seq_detector_param: RTL and testbench



---
 rtl/seq_detector_param_pkg.sv | 20 ++
 rtl/seq_detector_param_if.sv | 26 ++
 rtl/seq_detector_param_sat_counter.sv | 26 ++
 rtl/seq_detector_param.sv | 90 +++++++++
 tb/tb_seq_detector_param.sv | 262 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/seq_detector_param_pkg.sv
// Shared constants and helpers for the parametrised serial pattern detector.
//   DEF_PATTERN_1011 : default pattern of the legacy 4-bit detector
//   MODE_MEALY/MOORE : encoding of the MOORE parameter
//   clog2()          : width of the history fill counter
package seq_det_pkg;

    localparam logic [3:0] DEF_PATTERN_1011 = 4'b1011;

    localparam int unsigned MODE_MEALY = 0;
    localparam int unsigned MODE_MOORE = 1;

    // Ceiling log2, never less than 1 so a counter always has at least one bit.
    function automatic int unsigned clog2(input int unsigned n);
        int unsigned r;
        r = 0;
        while ((32'd1 << r) < n) r++;
        return (r == 0) ? 1 : r;
    endfunction

endpackage

// File: rtl/seq_detector_param_if.sv
// Serial data / pattern-control / match-report bundle of seq_detector_param.
//   master : data source + control logic (drives data, valid, overlap, load)
//   slave  : the detector (drives detected, match_count, pattern)
interface seq_detector_param_if #(
    parameter int unsigned PAT_W = 4,
    parameter int unsigned CNT_W = 8
);
    logic             data_in;
    logic             data_valid;
    logic             overlap_en;
    logic             pat_load;
    logic [PAT_W-1:0] pat_in;
    logic             detected;
    logic [CNT_W-1:0] match_count;
    logic [PAT_W-1:0] pattern;

    modport master (
        output data_in, data_valid, overlap_en, pat_load, pat_in,
        input  detected, match_count, pattern
    );

    modport slave (
        input  data_in, data_valid, overlap_en, pat_load, pat_in,
        output detected, match_count, pattern
    );
endinterface

// File: rtl/seq_detector_param_sat_counter.sv
// Saturating up-counter with synchronous clear.
//   clk, rst : clock and synchronous active-high reset
//   clr      : clear to zero (priority over inc)
//   inc      : increment by one, holding at all-ones
//   count    : current value
module sat_counter #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] count
);

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/seq_detector_param.sv
// Parametrised serial bit-pattern detector with loadable pattern, overlap
// control, Mealy/Moore output timing, valid qualification and a saturating
// match counter.
//   clk, rst : single clock, synchronous active-high reset
//   bus      : slave side of seq_detector_param_if
//              in : data_in, data_valid, overlap_en, pat_load, pat_in
//              out: detected, match_count, pattern
module seq_detector_param
    import seq_det_pkg::*;
#(
    parameter int unsigned      PAT_W   = 4,
    parameter logic [PAT_W-1:0] PATTERN = PAT_W'(DEF_PATTERN_1011),
    parameter int unsigned      MOORE   = MODE_MEALY,
    parameter int unsigned      CNT_W   = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    seq_detector_param_if.slave  bus
);

    localparam int unsigned      FILL_W   = clog2(PAT_W);
    localparam int unsigned      HIST_W   = PAT_W - 1;
    localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(PAT_W - 1);

    logic [PAT_W-1:0]  pat_q;
    logic [HIST_W-1:0] hist_q;
    logic [HIST_W-1:0] hist_d;
    logic [FILL_W-1:0] fill_q;
    logic [FILL_W-1:0] fill_d;
    logic [PAT_W-1:0]  window;
    logic              hit;
    logic              det_q;

    // Candidate window: stored history with the current bit as the newest (LSB).
    assign window = {hist_q, bus.data_in};

    // A load cycle discards the presented bit, so it can never complete a match.
    assign hit = bus.data_valid & ~bus.pat_load & (fill_q == FILL_MAX) & (window == pat_q);

    // Next history / fill; invalid cycles hold so gaps keep partial matches alive.
    always_comb begin
        hist_d = hist_q;
        fill_d = fill_q;
        if (bus.pat_load) begin
            hist_d = '0;
            fill_d = '0;
        end else if (bus.data_valid) begin
            hist_d = window[HIST_W-1:0];
            if (hit && !bus.overlap_en) begin
                // Non-overlap: the next match needs PAT_W fresh bits.
                fill_d = '0;
            end else if (fill_q != FILL_MAX) begin
                fill_d = fill_q + FILL_W'(1);
            end
        end
    end

    // Pattern, history, fill and Moore output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            pat_q  <= PATTERN;
            hist_q <= '0;
            fill_q <= '0;
            det_q  <= 1'b0;
        end else begin
            if (bus.pat_load) begin
                pat_q <= bus.pat_in;
            end
            hist_q <= hist_d;
            fill_q <= fill_d;
            det_q  <= hit;
        end
    end

    // Match counter, cleared with every pattern load.
    sat_counter #(
        .W (CNT_W)
    ) u_match_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (bus.pat_load),
        .inc   (hit),
        .count (bus.match_count)
    );

    // Mealy output is masked while reset is asserted.
    assign bus.detected = (MOORE == MODE_MOORE) ? det_q : (hit & ~rst);
    assign bus.pattern  = pat_q;

endmodule

// File: tb/tb_seq_detector_param.sv
// Self-checking bench for seq_detector_param: a Mealy/CNT_W=8, a Moore/CNT_W=8
// and a Mealy/CNT_W=2 instance share one stimulus stream. Directed scenarios
// plus a randomized run checked against a queue-based reference model.
module tb_seq_detector_param;

    logic       clk = 1'b0;
    logic       rst;
    logic       data_in;
    logic       data_valid;
    logic       overlap_en;
    logic       pat_load;
    logic [3:0] pat_in;

    int tests_run    = 0;
    int tests_failed = 0;

    // Reference model: valid bits seen since the last clear, oldest first.
    bit         m_bits[$];
    logic [3:0] m_pat;
    int         m_cnt;
    int         m_cnt2;
    bit         m_prev;

    always #5 clk = ~clk;

    seq_detector_param_if #(.PAT_W(4), .CNT_W(8)) if_a ();
    seq_detector_param_if #(.PAT_W(4), .CNT_W(8)) if_m ();
    seq_detector_param_if #(.PAT_W(4), .CNT_W(2)) if_c ();

    assign if_a.data_in = data_in;    assign if_m.data_in = data_in;    assign if_c.data_in = data_in;
    assign if_a.data_valid = data_valid; assign if_m.data_valid = data_valid; assign if_c.data_valid = data_valid;
    assign if_a.overlap_en = overlap_en; assign if_m.overlap_en = overlap_en; assign if_c.overlap_en = overlap_en;
    assign if_a.pat_load = pat_load;  assign if_m.pat_load = pat_load;  assign if_c.pat_load = pat_load;
    assign if_a.pat_in = pat_in;      assign if_m.pat_in = pat_in;      assign if_c.pat_in = pat_in;

    seq_detector_param #(.PAT_W(4), .PATTERN(4'b1011), .MOORE(0), .CNT_W(8))
        dut_a (.clk(clk), .rst(rst), .bus(if_a));
    seq_detector_param #(.PAT_W(4), .PATTERN(4'b1011), .MOORE(1), .CNT_W(8))
        dut_m (.clk(clk), .rst(rst), .bus(if_m));
    seq_detector_param #(.PAT_W(4), .PATTERN(4'b1011), .MOORE(0), .CNT_W(2))
        dut_c (.clk(clk), .rst(rst), .bus(if_c));

    // Match if the last three valid bits plus the current bit spell the pattern.
    function automatic bit model_hit();
        logic [3:0] w;
        int n;
        n = m_bits.size();
        if (rst || !data_valid || pat_load || n < 3) return 1'b0;
        w = {m_bits[n-3], m_bits[n-2], m_bits[n-1], data_in};
        return (w == m_pat);
    endfunction

    task automatic model_commit();
        bit h;
        h = model_hit();
        if (rst) begin
            m_bits.delete(); m_pat = 4'b1011; m_cnt = 0; m_cnt2 = 0; m_prev = 1'b0;
        end else if (pat_load) begin
            m_bits.delete(); m_pat = pat_in; m_cnt = 0; m_cnt2 = 0; m_prev = 1'b0;
        end else begin
            m_prev = h;
            if (data_valid) begin
                m_bits.push_back(data_in);
                if (m_bits.size() > 8) void'(m_bits.pop_front());
                if (h) begin
                    if (m_cnt < 255) m_cnt++;
                    if (m_cnt2 < 3) m_cnt2++;
                    if (!overlap_en) m_bits.delete();
                end
            end
        end
    endtask

    task automatic drive(input logic d, input logic v, input logic ov, input logic ld,
                         input logic [3:0] pin, input logic r);
        data_in = d; data_valid = v; overlap_en = ov; pat_load = ld; pat_in = pin; rst = r;
    endtask

    // Called at the negedge: advance the model, then cross the active edge.
    task automatic tick();
        model_commit();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        drive(1'b0, 1'b0, 1'b1, 1'b0, 4'b0000, 1'b1);
        @(negedge clk);
        tick();
    endtask

    task automatic test_reset();
        drive(1'b1, 1'b1, 1'b1, 1'b0, 4'b0000, 1'b1);
        @(negedge clk);
        tests_run++; if (if_a.detected !== 1'b0) begin tests_failed++; $display("FAIL reset_mealy_det: got %b expected 0", if_a.detected); end
        tests_run++; if (if_m.detected !== 1'b0) begin tests_failed++; $display("FAIL reset_moore_det: got %b expected 0", if_m.detected); end
        tests_run++; if (if_a.match_count !== 8'd0) begin tests_failed++; $display("FAIL reset_count: got %0d expected 0", if_a.match_count); end
        tests_run++; if (if_a.pattern !== 4'b1011) begin tests_failed++; $display("FAIL reset_pattern: got %b expected 1011", if_a.pattern); end
        tick();
        drive(1'b0, 1'b0, 1'b1, 1'b0, 4'b0000, 1'b0);
        @(negedge clk);
        tests_run++; if (if_m.detected !== 1'b0) begin tests_failed++; $display("FAIL post_reset_moore_det: got %b expected 0", if_m.detected); end
        tests_run++; if (if_c.match_count !== 2'd0) begin tests_failed++; $display("FAIL post_reset_count2: got %0d expected 0", if_c.match_count); end
        tick();
    endtask

    // Stream 1011011 with overlap enabled (ov=1) or disabled (ov=0).
    task automatic test_stream(input logic ov);
        logic [6:0] s;
        logic exp_a, exp_m;
        s = 7'b1011011;
        do_reset();
        for (int i = 0; i < 8; i++) begin
            if (i < 7) drive(s[6-i], 1'b1, ov, 1'b0, 4'b0000, 1'b0);
            else       drive(1'b0, 1'b0, ov, 1'b0, 4'b0000, 1'b0);
            @(negedge clk);
            exp_a = (i == 3) || (ov && i == 6);
            exp_m = (i == 4) || (ov && i == 7);
            tests_run++; if (if_a.detected !== exp_a) begin tests_failed++; $display("FAIL stream_ov%0b_mealy[%0d]: got %b expected %b", ov, i, if_a.detected, exp_a); end
            tests_run++; if (if_m.detected !== exp_m) begin tests_failed++; $display("FAIL stream_ov%0b_moore[%0d]: got %b expected %b", ov, i, if_m.detected, exp_m); end
            tick();
        end
        @(negedge clk);
        tests_run++; if (if_a.match_count !== (ov ? 8'd2 : 8'd1)) begin tests_failed++; $display("FAIL stream_ov%0b_count: got %0d expected %0d", ov, if_a.match_count, ov ? 2 : 1); end
    endtask

    task automatic test_load_zeros();
        logic exp_a;
        // A zero presented during the load must not count toward the new pattern.
        drive(1'b0, 1'b1, 1'b1, 1'b1, 4'b0000, 1'b0);
        @(negedge clk);
        tests_run++; if (if_a.detected !== 1'b0) begin tests_failed++; $display("FAIL load_cycle_det: got %b expected 0", if_a.detected); end
        tick();
        for (int i = 0; i < 7; i++) begin
            drive(1'b0, 1'b1, 1'b1, 1'b0, 4'b0000, 1'b0);
            @(negedge clk);
            if (i == 0) begin
                tests_run++; if (if_a.match_count !== 8'd0) begin tests_failed++; $display("FAIL load_count_clr: got %0d expected 0", if_a.match_count); end
                tests_run++; if (if_a.pattern !== 4'b0000) begin tests_failed++; $display("FAIL load_pattern: got %b expected 0000", if_a.pattern); end
            end
            exp_a = (i >= 3);
            tests_run++; if (if_a.detected !== exp_a) begin tests_failed++; $display("FAIL zeros_mealy[%0d]: got %b expected %b", i, if_a.detected, exp_a); end
            tick();
        end
        drive(1'b0, 1'b0, 1'b1, 1'b0, 4'b0000, 1'b0);
        @(negedge clk);
        tests_run++; if (if_a.match_count !== 8'd4) begin tests_failed++; $display("FAIL zeros_count: got %0d expected 4", if_a.match_count); end
        tests_run++; if (if_c.match_count !== 2'd3) begin tests_failed++; $display("FAIL zeros_count2_sat: got %0d expected 3", if_c.match_count); end
        tests_run++; if (if_m.detected !== 1'b1) begin tests_failed++; $display("FAIL zeros_moore_last: got %b expected 1", if_m.detected); end
        tick();
    endtask

    task automatic test_gaps();
        logic [3:0] s;
        s = 4'b1011;
        do_reset();
        for (int b = 0; b < 4; b++) begin
            drive(s[3-b], 1'b1, 1'b1, 1'b0, 4'b0000, 1'b0);
            @(negedge clk);
            tests_run++; if (if_a.detected !== (b == 3)) begin tests_failed++; $display("FAIL gaps_bit[%0d]: got %b expected %b", b, if_a.detected, b == 3); end
            tick();
            if (b < 3) begin
                for (int g = 0; g < 3; g++) begin
                    drive(1'($urandom_range(0, 1)), 1'b0, 1'b1, 1'b0, 4'b0000, 1'b0);
                    @(negedge clk);
                    tests_run++; if (if_a.detected !== 1'b0) begin tests_failed++; $display("FAIL gaps_idle_mealy[%0d.%0d]: got %b expected 0", b, g, if_a.detected); end
                    tests_run++; if (if_m.detected !== 1'b0) begin tests_failed++; $display("FAIL gaps_idle_moore[%0d.%0d]: got %b expected 0", b, g, if_m.detected); end
                    tick();
                end
            end
        end
        drive(1'b1, 1'b0, 1'b1, 1'b0, 4'b0000, 1'b0);
        @(negedge clk);
        tests_run++; if (if_m.detected !== 1'b1) begin tests_failed++; $display("FAIL gaps_moore_pulse: got %b expected 1", if_m.detected); end
        tests_run++; if (if_a.match_count !== 8'd1) begin tests_failed++; $display("FAIL gaps_count: got %0d expected 1", if_a.match_count); end
        tick();
    endtask

    task automatic test_saturate();
        logic [15:0] s;
        int n;
        s = 16'b1011011011011011;
        do_reset();
        for (int i = 0; i < 17; i++) begin
            if (i < 16) drive(s[15-i], 1'b1, 1'b1, 1'b0, 4'b0000, 1'b0);
            else        drive(1'b0, 1'b0, 1'b1, 1'b0, 4'b0000, 1'b0);
            @(negedge clk);
            n = (i - 1) / 3;
            if (n > 3) n = 3;
            tests_run++; if (if_c.match_count !== 2'(n)) begin tests_failed++; $display("FAIL sat_count2[%0d]: got %0d expected %0d", i, if_c.match_count, n); end
            tests_run++; if (if_a.detected !== (i >= 3 && i < 16 && i % 3 == 0)) begin tests_failed++; $display("FAIL sat_mealy[%0d]: got %b", i, if_a.detected); end
            tick();
        end
        @(negedge clk);
        tests_run++; if (if_a.match_count !== 8'd5) begin tests_failed++; $display("FAIL sat_count8: got %0d expected 5", if_a.match_count); end
    endtask

    task automatic test_reset_mid();
        logic [2:0] pre;
        logic [4:0] post;
        pre  = 3'b101;
        post = 5'b11011;
        do_reset();
        for (int i = 0; i < 3; i++) begin
            drive(pre[2-i], 1'b1, 1'b1, 1'b0, 4'b0000, 1'b0);
            @(negedge clk);
            tick();
        end
        // The bit presented with reset would complete 1011 but must be masked.
        drive(1'b1, 1'b1, 1'b1, 1'b0, 4'b0000, 1'b1);
        @(negedge clk);
        tests_run++; if (if_a.detected !== 1'b0) begin tests_failed++; $display("FAIL midrst_mealy: got %b expected 0", if_a.detected); end
        tick();
        for (int i = 0; i < 6; i++) begin
            if (i < 5) drive(post[4-i], 1'b1, 1'b1, 1'b0, 4'b0000, 1'b0);
            else       drive(1'b0, 1'b0, 1'b1, 1'b0, 4'b0000, 1'b0);
            @(negedge clk);
            tests_run++; if (if_a.detected !== (i == 4)) begin tests_failed++; $display("FAIL midrst_mealy[%0d]: got %b expected %b", i, if_a.detected, i == 4); end
            tests_run++; if (if_m.detected !== (i == 5)) begin tests_failed++; $display("FAIL midrst_moore[%0d]: got %b expected %b", i, if_m.detected, i == 5); end
            if (i == 0) begin
                tests_run++; if (if_a.match_count !== 8'd0) begin tests_failed++; $display("FAIL midrst_count: got %0d expected 0", if_a.match_count); end
            end
            tick();
        end
    endtask

    task automatic test_random();
        logic ov;
        ov = 1'b1;
        do_reset();
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 15) == 0) ov = ~ov;
            drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 9) < 7), ov,
                  1'($urandom_range(0, 39) == 0), 4'($urandom_range(0, 15)),
                  1'($urandom_range(0, 79) == 0));
            @(negedge clk);
            tests_run++; if (if_a.detected !== model_hit()) begin tests_failed++; $display("FAIL rnd_mealy[%0d]: got %b expected %b", i, if_a.detected, model_hit()); end
            tests_run++; if (if_m.detected !== m_prev) begin tests_failed++; $display("FAIL rnd_moore[%0d]: got %b expected %b", i, if_m.detected, m_prev); end
            tests_run++; if (if_a.match_count !== 8'(m_cnt)) begin tests_failed++; $display("FAIL rnd_count[%0d]: got %0d expected %0d", i, if_a.match_count, m_cnt); end
            tests_run++; if (if_c.match_count !== 2'(m_cnt2)) begin tests_failed++; $display("FAIL rnd_count2[%0d]: got %0d expected %0d", i, if_c.match_count, m_cnt2); end
            tests_run++; if (if_a.pattern !== m_pat) begin tests_failed++; $display("FAIL rnd_pattern[%0d]: got %b expected %b", i, if_a.pattern, m_pat); end
            tick();
        end
    endtask

    initial begin
        drive(1'b0, 1'b0, 1'b1, 1'b0, 4'b0000, 1'b1);
        @(negedge clk);
        tick();
        test_reset();
        test_stream(1'b1);
        test_stream(1'b0);
        test_load_zeros();
        test_gaps();
        test_saturate();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
